// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared declarations for the FIR serial output stage:
//   DATA_WIDTH_DEF : default sample width
//   tx_state_t     : serializer states (IDLE, REQ, SHIFT, GAP)
//   cnt_width()    : width of a counter that must hold the values 0..n-1
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int DATA_WIDTH_DEF = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } tx_state_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// ---------------------------------------------------------------------------
// fir_sync_fifo
// Single-clock FIFO that buffers parallel samples ahead of the serializer.
// Full/empty use one extra pointer MSB, so all DEPTH slots are usable.
// The occupancy count is registered.
//
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset (empties the FIFO)
//   i_en     enable; low freezes pointers, count and memory
//   i_wr     write request (refused while full)
//   i_wdata  write data
//   i_rd     pop request (ignored while empty)
//   o_rdata  head of the FIFO (valid while not empty)
//   o_full   FIFO full
//   o_empty  FIFO empty
//   o_count  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_wr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic                    i_rd,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic [AW:0]           r_count;
    logic                  w_push;
    logic                  w_pop;

    // Same slot index with differing wrap bits means the writer lapped the reader.
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign w_push  = i_en && i_wr && !o_full;
    assign w_pop   = i_en && i_rd && !o_empty;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/fir_serial_tx.sv
// ---------------------------------------------------------------------------
// fir_serial_tx
// Output stage of the FIR datapath: buffers parallel samples in a FIFO and
// serializes each one LSB-first behind a valid/ready handshake.
//
// Optional build macro FIR_TX_PARITY_EN: when defined, every frame carries
// one extra trailing even-parity bit (XOR of all data bits).
//
// Ports:
//   i_clk         clock
//   i_rst         synchronous active-high reset; aborts any word in flight
//   i_en          global enable; low freezes all state
//   i_word        parallel sample from the FIR core
//   i_word_valid  i_word valid this cycle
//   o_word_ready  FIFO can accept a word (not full, enabled, not in reset)
//   i_ready       serial consumer ready
//   o_dout        serial data, LSB first
//   o_dout_valid  a word is pending (REQ) or being shifted (SHIFT)
//   o_fifo_count  FIFO occupancy
//   o_overflow    sticky: a write was offered while the FIFO was full
// ---------------------------------------------------------------------------
module fir_serial_tx
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic [DATA_WIDTH-1:0]        i_word,
    input  logic                         i_word_valid,
    output logic                         o_word_ready,
    input  logic                         i_ready,
    output logic                         o_dout,
    output logic                         o_dout_valid,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
    output logic                         o_overflow
);

`ifdef FIR_TX_PARITY_EN
    localparam int FRAME_W = DATA_WIDTH + 1;
`else
    localparam int FRAME_W = DATA_WIDTH;
`endif
    localparam int               BIT_W    = cnt_width(FRAME_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam int               GAP_W    = cnt_width((GAP_CYCLES > 0) ? GAP_CYCLES : 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_t              r_state;
    logic [FRAME_W-1:0]     r_shreg;
    logic [BIT_W-1:0]       r_bitcnt;
    logic [GAP_W-1:0]       r_gapcnt;
    logic                   r_dout;
    logic                   r_dout_valid;
    logic                   r_overflow;

    logic [DATA_WIDTH-1:0]  w_head;
    logic [FRAME_W-1:0]     w_frame;
    logic                   w_full;
    logic                   w_empty;

    fir_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_wr    (i_word_valid),
        .i_wdata (i_word),
        .i_rd    (r_state == IDLE),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_fifo_count)
    );

`ifdef FIR_TX_PARITY_EN
    // Parity rides in the shift register above the data so SHIFT needs no special case.
    assign w_frame = {^w_head, w_head};
`else
    assign w_frame = w_head;
`endif

    // Ready comes from the registered full flag, so a pop on a full FIFO
    // does not open room for a same-cycle write.
    assign o_word_ready = i_en && !i_rst && !w_full;
    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_overflow   = r_overflow;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_bitcnt     <= '0;
            r_gapcnt     <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (i_en) begin
            if (i_word_valid && w_full) r_overflow <= 1'b1;

            case (r_state)
                IDLE: begin
                    r_dout       <= 1'b0;
                    r_dout_valid <= 1'b0;
                    // FIFO pops on this same edge (its i_rd is state == IDLE).
                    if (!w_empty) begin
                        r_shreg      <= w_frame;
                        r_dout_valid <= 1'b1;
                        r_state      <= REQ;
                    end
                end
                REQ: begin
                    if (i_ready) begin
                        r_dout   <= r_shreg[0];
                        r_shreg  <= r_shreg >> 1;
                        r_bitcnt <= '0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // r_bitcnt is the index of the bit currently on o_dout.
                    if (r_bitcnt == BIT_LAST) begin
                        r_dout       <= 1'b0;
                        r_dout_valid <= 1'b0;
                        r_gapcnt     <= '0;
                        r_state      <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        r_bitcnt <= r_bitcnt + 1'b1;
                        r_dout   <= r_shreg[0];
                        r_shreg  <= r_shreg >> 1;
                    end
                end
                GAP: begin
                    if (r_gapcnt == GAP_LAST) r_state <= IDLE;
                    else                      r_gapcnt <= r_gapcnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_serial_tx.sv
module tb_fir_serial_tx;

    localparam int DW    = 24;
    localparam int DEPTH = 8;
    localparam int GAPC  = 2;
`ifdef FIR_TX_PARITY_EN
    localparam int FRAME = DW + 1;
`else
    localparam int FRAME = DW;
`endif
    // Word period with i_ready high: IDLE pop + REQ + frame + gap.
    localparam int SPACING = FRAME + GAPC + 2;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_en = 1'b1;
    logic [DW-1:0] i_word = '0;
    logic          i_word_valid = 1'b0;
    logic          o_word_ready;
    logic          i_ready = 1'b0;
    logic          o_dout;
    logic          o_dout_valid;
    logic [3:0]    o_fifo_count;
    logic          o_overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] w;
    int          hs;
    int          prev_hs;
    int          seen;
    logic [DW-1:0] rw1;

    logic [31:0] expq[$];
    logic [31:0] rxq[$];
    logic        rxing;
    int          ridx;
    logic [31:0] rword;

    always #5 clk = ~clk;

    fir_serial_tx #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAPC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .i_ready      (i_ready),
        .o_dout       (o_dout),
        .o_dout_valid (o_dout_valid),
        .o_fifo_count (o_fifo_count),
        .o_overflow   (o_overflow)
    );

    // Expected serial frame: data bits LSB first, optional even parity on top.
    function automatic logic [31:0] frame_of(input logic [DW-1:0] d);
        logic [31:0] f;
        logic        p;
        f = 32'(d);
        p = 1'b0;
        for (int i = 0; i < DW; i++) p = p ^ d[i];
`ifdef FIR_TX_PARITY_EN
        f[DW] = p;
`endif
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write1(input logic [DW-1:0] d);
        i_word       = d;
        i_word_valid = 1'b1;
        step();
        i_word_valid = 1'b0;
    endtask

    // Consumer: wait (bounded) for valid, handshake, then collect FRAME bits.
    // freeze_at >= 0 drops i_en for 3 cycles while bit freeze_at is on the line.
    task automatic rx(input int freeze_at, output logic [31:0] wo, output int hso);
        int n;
        int badv;
        n    = 0;
        badv = 0;
        wo   = '0;
        while (o_dout_valid !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("rx_wait_valid", 32'(o_dout_valid), 32'd1);
        i_ready = 1'b1;
        step();
        hso = cyc;
        for (int k = 0; k < FRAME; k++) begin
            wo[k] = o_dout;
            if (o_dout_valid !== 1'b1) badv++;
            if (k == freeze_at) begin
                i_en = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    step();
                    chk("en_hold_dout", 32'(o_dout), 32'(wo[k]));
                    chk("en_ready_low", 32'(o_word_ready), 32'd0);
                end
                i_en = 1'b1;
            end
            step();
        end
        chk("rx_frame_valid_high", 32'(badv), 32'd0);
        chk("rx_end_valid_low", 32'(o_dout_valid), 32'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_dout", 32'(o_dout), 32'd0);
        chk("rst_valid", 32'(o_dout_valid), 32'd0);
        chk("rst_count", 32'(o_fifo_count), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_ready", 32'(o_word_ready), 32'd0);
        i_rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(o_word_ready), 32'd1);

        // ---------------- single word, latency and gap ----------------
        i_ready = 1'b1;
        write1(24'h800001);
        chk("lat_after_write_valid", 32'(o_dout_valid), 32'd0);
        chk("lat_after_write_count", 32'(o_fifo_count), 32'd1);
        step();
        chk("lat_pop_valid", 32'(o_dout_valid), 32'd1);
        chk("lat_pop_dout", 32'(o_dout), 32'd0);
        chk("lat_pop_count", 32'(o_fifo_count), 32'd0);
        rx(-1, w, hs);
        chk("t1_word", w, frame_of(24'h800001));
        step();
        chk("t1_gap2_valid", 32'(o_dout_valid), 32'd0);
        chk("t1_gap2_dout", 32'(o_dout), 32'd0);
        repeat (4) step();

        // ---------------- fill FIFO with consumer stalled ----------------
        i_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            i_word       = DW'(k);
            i_word_valid = 1'b1;
            chk("fill_ready", 32'(o_word_ready), 32'd1);
            step();
        end
        chk("fill_count7", 32'(o_fifo_count), 32'd7);
        i_word = DW'(9);
        chk("fill9_ready", 32'(o_word_ready), 32'd1);
        step();
        chk("fill9_count", 32'(o_fifo_count), 32'd8);
        chk("fill9_ready_low", 32'(o_word_ready), 32'd0);
        chk("fill9_ovf", 32'(o_overflow), 32'd0);
        i_word = DW'(10);
        step();
        i_word_valid = 1'b0;
        chk("ovf_set", 32'(o_overflow), 32'd1);
        chk("ovf_count", 32'(o_fifo_count), 32'd8);
        prev_hs = 0;
        for (int k = 1; k <= 9; k++) begin
            rx(-1, w, hs);
            chk("drain_word", w, frame_of(DW'(k)));
            if (k > 1) chk("drain_spacing", 32'(hs - prev_hs), 32'(SPACING));
            prev_hs = hs;
        end
        repeat (4) step();
        chk("drain_empty", 32'(o_fifo_count), 32'd0);

        // ---------------- late ready held in REQ ----------------
        i_ready = 1'b0;
        rw1 = DW'($urandom);
        write1(rw1);
        step();
        chk("late_req_valid", 32'(o_dout_valid), 32'd1);
        for (int j = 0; j < 5; j++) begin
            step();
            chk("late_hold_valid", 32'(o_dout_valid), 32'd1);
            chk("late_hold_dout", 32'(o_dout), 32'd0);
        end
        rx(-1, w, hs);
        chk("late_word", w, frame_of(rw1));
        repeat (4) step();

        // ---------------- enable freeze mid-shift ----------------
        i_ready = 1'b1;
        write1(24'hA5A5A5);
        rx(5, w, hs);
        chk("freeze_word", w, frame_of(24'hA5A5A5));
        repeat (4) step();

        // ---------------- reset mid-word ----------------
        chk("ovf_sticky", 32'(o_overflow), 32'd1);
        rw1 = DW'($urandom);
        write1(rw1);
        write1(DW'($urandom));
        write1(DW'($urandom));
        repeat (10) step();
        chk("rst_mid_count", 32'(o_fifo_count), 32'd2);
        chk("rst_mid_bit10", 32'(o_dout), 32'(rw1[10]));
        i_rst = 1'b1;
        step();
        chk("rst_mid_dout", 32'(o_dout), 32'd0);
        chk("rst_mid_valid", 32'(o_dout_valid), 32'd0);
        chk("rst_mid_count0", 32'(o_fifo_count), 32'd0);
        chk("rst_mid_ovf", 32'(o_overflow), 32'd0);
        chk("rst_mid_ready", 32'(o_word_ready), 32'd0);
        i_rst = 1'b0;
        seen = 0;
        repeat (40) begin
            step();
            if (o_dout_valid !== 1'b0) seen++;
        end
        chk("rst_no_output", 32'(seen), 32'd0);
        chk("rst_still_empty", 32'(o_fifo_count), 32'd0);

`ifdef FIR_TX_PARITY_EN
        // ---------------- parity bit ----------------
        write1(24'h000007);
        rx(-1, w, hs);
        chk("parity7_bit", 32'(w[DW]), 32'd1);
        chk("parity7_frame", w, frame_of(24'h000007));
        write1(24'h000003);
        rx(-1, w, hs);
        chk("parity3_bit", 32'(w[DW]), 32'd0);
        chk("parity3_frame", w, frame_of(24'h000003));
        repeat (4) step();
`endif

        // ---------------- randomized traffic vs scoreboard ----------------
        rxing = 1'b0;
        ridx  = 0;
        rword = '0;
        for (int c = 0; c < 800; c++) begin
            if (c < 400) begin
                i_word_valid = 1'($urandom_range(0, 1));
                i_word       = DW'($urandom);
                i_ready      = ($urandom_range(0, 3) != 0);
            end else begin
                i_word_valid = 1'b0;
                i_ready      = 1'b1;
            end
            if (i_word_valid && o_word_ready) expq.push_back(frame_of(i_word));
            if (rxing) begin
                rword[ridx] = o_dout;
                ridx++;
                if (ridx == FRAME) begin
                    rxq.push_back(rword);
                    rxing = 1'b0;
                end
            end else if (o_dout_valid && i_ready) begin
                rxing = 1'b1;
                ridx  = 0;
                rword = '0;
            end
            step();
        end
        chk("rand_word_count", 32'(rxq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
            chk("rand_word", rxq[i], expq[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
